// File: rtl/rotate_engine.sv
// rotate_engine
// Holds a WIDTH-bit pattern and rotates it by STEP bits (one display digit
// by default), either on a prescaled auto tick or on a manual step pulse.
// Modes: 00 rotate left, 01 rotate right, 10 bounce (ping-pong), 11 freeze.
//
// Ports:
//   CLK100MHZ   in   system clock
//   CPU_RESET   in   synchronous active-high reset
//   load        in   load load_val on the next edge (beats any step)
//   load_val    in   WIDTH-bit value to load
//   mode        in   2-bit rotation mode
//   run         in   enable auto-stepping on prescaler tick
//   step_now    in   single-cycle manual step request
//   pattern     out  current pattern (registered)
//   pos         out  digit position 0..N-1, N = WIDTH/STEP
//   dir         out  direction of the last step (0 left, 1 right)
//   step_pulse  out  high for the one cycle after pattern has stepped
module rotate_engine #(
    parameter int               WIDTH = 16,
    parameter int               STEP  = 4,
    parameter int               DIV   = 50_000_000,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                              CLK100MHZ,
    input  logic                              CPU_RESET,
    input  logic                              load,
    input  logic [WIDTH-1:0]                  load_val,
    input  logic [1:0]                        mode,
    input  logic                              run,
    input  logic                              step_now,
    output logic [WIDTH-1:0]                  pattern,
    output logic [$clog2(WIDTH/STEP)-1:0]     pos,
    output logic                              dir,
    output logic                              step_pulse
);

    localparam int N     = WIDTH / STEP;
    localparam int POS_W = $clog2(N);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-STEP-1:0], v[WIDTH-1:WIDTH-STEP]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        return {v[STEP-1:0], v[WIDTH-1:STEP]};
    endfunction

    logic [WIDTH-1:0] pattern_r;
    logic [POS_W-1:0] pos_r;
    logic             dir_r;
    logic             step_pulse_r;
    logic [CNT_W-1:0] cnt_r;

    logic             frozen_s;
    logic             tick_s;
    logic             step_s;
    logic             go_right_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Tick, step qualification and prescaler next value
    always_comb begin
        frozen_s  = (mode == 2'b11);
        // Gating with run keeps DIV=1 (count always at max) from ticking while idle.
        tick_s    = run && !frozen_s && (cnt_r == CNT_MAX);
        step_s    = (tick_s || step_now) && !frozen_s;
        cnt_nxt_s = CNT_ZERO;
        if (!run || frozen_s || load) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (tick_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Direction of the pending step; bounce reverses at the ends on the same edge
    always_comb begin
        go_right_s = 1'b0;
        case (mode)
            2'b00: go_right_s = 1'b0;
            2'b01: go_right_s = 1'b1;
            2'b10: begin
                if (dir_r == 1'b0) begin
                    go_right_s = (pos_r == POS_MAX);
                end else begin
                    go_right_s = (pos_r != POS_ZERO);
                end
            end
            default: go_right_s = 1'b0;
        endcase
    end

    // Prescaler register
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Pattern, position, direction and step pulse registers
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            pattern_r    <= INIT;
            pos_r        <= POS_ZERO;
            dir_r        <= 1'b0;
            step_pulse_r <= 1'b0;
        end else if (load) begin
            pattern_r    <= load_val;
            pos_r        <= POS_ZERO;
            dir_r        <= 1'b0;
            step_pulse_r <= 1'b0;
        end else if (step_s) begin
            step_pulse_r <= 1'b1;
            if (go_right_s) begin
                pattern_r <= rot_right(pattern_r);
                pos_r     <= (pos_r == POS_ZERO) ? POS_MAX : (pos_r - POS_ONE);
                dir_r     <= 1'b1;
            end else begin
                pattern_r <= rot_left(pattern_r);
                pos_r     <= (pos_r == POS_MAX) ? POS_ZERO : (pos_r + POS_ONE);
                dir_r     <= 1'b0;
            end
        end else begin
            step_pulse_r <= 1'b0;
        end
    end

    assign pattern    = pattern_r;
    assign pos        = pos_r;
    assign dir        = dir_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_rotate_engine.sv
// Scoreboard bench for rotate_engine (WIDTH=16, STEP=4, DIV=4, INIT=0x0001).
// The stimulus process drives inputs on the falling edge, advances a
// behavioural reference model and queues the expected post-edge state; the
// monitor pops one record after every rising edge and compares.
module tb_rotate_engine;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int D   = 4;
    localparam int N   = W / S;

    logic          clk;
    logic          rst;
    logic          load;
    logic [W-1:0]  load_val;
    logic [1:0]    mode;
    logic          run;
    logic          step_now;
    logic [W-1:0]  pattern;
    logic [1:0]    pos;
    logic          dir;
    logic          step_pulse;

    rotate_engine #(.WIDTH(W), .STEP(S), .DIV(D), .INIT(16'h0001)) dut (
        .CLK100MHZ (clk),
        .CPU_RESET (rst),
        .load      (load),
        .load_val  (load_val),
        .mode      (mode),
        .run       (run),
        .step_now  (step_now),
        .pattern   (pattern),
        .pos       (pos),
        .dir       (dir),
        .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pat;
        int           p;
        bit           d;
        bit           sp;
        bit           has_gold;
        logic [W-1:0] gold;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_pat = 16'h0001;
    int           m_pos = 0;
    bit           m_dir = 1'b0;
    int           m_cyc = 0;   // cycles since prescaler restart

    function automatic logic [W-1:0] rl(input logic [W-1:0] v);
        logic [31:0] w;
        w = {16'h0000, v};
        return 16'((w << S) | (w >> (W - S)));
    endfunction

    function automatic logic [W-1:0] rr(input logic [W-1:0] v);
        logic [31:0] w;
        w = {16'h0000, v};
        return 16'((w >> S) | (w << (W - S)));
    endfunction

    task automatic drive(input bit r, input bit ld, input logic [W-1:0] lv,
                         input logic [1:0] md, input bit rn, input bit sn,
                         input bit hg, input logic [W-1:0] gv);
        exp_t e;
        bit   frozen, tick, right, sp;
        @(negedge clk);
        rst = r; load = ld; load_val = lv; mode = md; run = rn; step_now = sn;
        sp = 1'b0;
        if (r) begin
            m_pat = 16'h0001; m_pos = 0; m_dir = 1'b0; m_cyc = 0;
        end else begin
            frozen = (md == 2'd3);
            tick   = rn && !frozen && (m_cyc == D - 1);
            if (!rn || frozen || ld || tick) m_cyc = 0;
            else m_cyc = m_cyc + 1;
            if (ld) begin
                m_pat = lv; m_pos = 0; m_dir = 1'b0;
            end else if ((tick || sn) && !frozen) begin
                if (md == 2'd0) right = 1'b0;
                else if (md == 2'd1) right = 1'b1;
                else if (!m_dir) right = (m_pos == N - 1);
                else right = (m_pos != 0);
                if (right) begin
                    m_pat = rr(m_pat); m_pos = (m_pos + N - 1) % N; m_dir = 1'b1;
                end else begin
                    m_pat = rl(m_pat); m_pos = (m_pos + 1) % N; m_dir = 1'b0;
                end
                sp = 1'b1;
            end
        end
        e.pat = m_pat; e.p = m_pos; e.d = m_dir; e.sp = sp;
        e.has_gold = hg; e.gold = gv;
        q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] md, input bit rn, input bit hg, input logic [W-1:0] gv);
        drive(1'b0, 1'b0, 16'h0000, md, rn, 1'b0, hg, gv);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per rising edge, sampled 1 time unit later
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pattern", int'(pattern), int'(e.pat));
            cmp("pos", int'(pos), e.p);
            cmp("dir", int'(dir), int'(e.d));
            cmp("step_pulse", int'(step_pulse), int'(e.sp));
            if (e.has_gold) cmp("pattern_golden", int'(pattern), int'(e.gold));
        end
    end

    initial begin
        logic [W-1:0] seq2 [4];
        logic [W-1:0] seq4 [7];
        seq2 = '{16'h2341, 16'h3412, 16'h4123, 16'h1234};
        seq4 = '{16'h00F0, 16'h0F00, 16'hF000, 16'h0F00, 16'h00F0, 16'h000F, 16'h00F0};
        rst = 1'b1; load = 1'b0; load_val = 16'h0000; mode = 2'b00; run = 1'b0; step_now = 1'b0;

        // 1: reset held two cycles, then idle
        drive(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0001);
        drive(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 20; i++) idle(2'b00, 1'b0, 1'b1, 16'h0001);

        // 2: rotate left every 4 cycles with wrap
        drive(1'b0, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 1; i <= 16; i++) idle(2'b00, 1'b1, (i % 4) == 0, seq2[(i - 1) / 4]);

        // 3: rotate right
        drive(1'b0, 1'b1, 16'h1234, 2'b01, 1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 1; i <= 8; i++) idle(2'b01, 1'b1, (i % 4) == 0, (i == 4) ? 16'h4123 : 16'h3412);

        // 4: bounce across both ends
        drive(1'b0, 1'b1, 16'h000F, 2'b10, 1'b1, 1'b0, 1'b1, 16'h000F);
        for (int i = 1; i <= 28; i++) idle(2'b10, 1'b1, (i % 4) == 0, seq4[(i - 1) / 4]);

        // 5: manual step, coincident tick+step_now, freeze ignores step_now
        drive(1'b0, 1'b1, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0001);
        drive(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0010);
        idle(2'b00, 1'b0, 1'b1, 16'h0010);
        drive(1'b0, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 1; i <= 3; i++) idle(2'b00, 1'b1, 1'b1, 16'h1234);
        drive(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 16'h2341);
        idle(2'b00, 1'b0, 1'b1, 16'h2341);
        drive(1'b0, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b1, 16'h2341);
        drive(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h2341);

        // 6: load beats a tick; next step 4 cycles after the load
        drive(1'b0, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 1; i <= 3; i++) idle(2'b00, 1'b1, 1'b1, 16'h1234);
        drive(1'b0, 1'b1, 16'hABCD, 2'b00, 1'b1, 1'b0, 1'b1, 16'hABCD);
        for (int i = 1; i <= 4; i++) idle(2'b00, 1'b1, 1'b1, (i == 4) ? 16'hBCDA : 16'hABCD);

        // 6: reset mid-bounce at pos2, dir1
        drive(1'b0, 1'b1, 16'h000F, 2'b10, 1'b1, 1'b0, 1'b1, 16'h000F);
        for (int i = 1; i <= 16; i++) idle(2'b10, 1'b1, (i == 16), 16'h0F00);
        drive(1'b1, 1'b0, 16'h0000, 2'b10, 1'b1, 1'b0, 1'b1, 16'h0001);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 64) == 0, ($urandom % 16) == 0, 16'($urandom),
                  2'($urandom), ($urandom % 4) != 0, ($urandom % 4) == 0,
                  1'b0, 16'h0000);
        end

        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_engine.md
Name: rotate_engine

Overview:
- Parametrised rotating-pattern engine; successor to the 2-bit-select fixed rotator.
- Holds a WIDTH-bit pattern and rotates it by STEP bits (one 7-seg digit by default). Rotation runs on a prescaled tick or a manual step.
- Modes: rotate-left, rotate-right, bounce (ping-pong) and freeze.
- Output `pattern` feeds the `t` input of `sev_seg_top`; `load_val`, `mode` and `run` come from the switches in Top.

Parameters:
- WIDTH, 16, pattern width in bits. Must be a multiple of STEP.
- STEP, 4, bits moved per step. 1 <= STEP < WIDTH.
- DIV, 50_000_000, clock cycles per auto-step tick. DIV >= 1.
- INIT, 'h0001, pattern value after reset (WIDTH bits).

Ports:
- CLK100MHZ  input  1  system clock.
- CPU_RESET  input  1  reset, synchronous and active-high.
- load  input  1  when high, loads `load_val` on the next edge.
- load_val  input  WIDTH  value to load.
- mode  input  2  00 left, 01 right, 10 bounce, 11 freeze.
- run  input  1  1 = auto-step on prescaler tick.
- step_now  input  1  single-cycle pulse requesting one manual step.
- pattern  output  WIDTH  current pattern (registered).
- pos  output  $clog2(WIDTH/STEP)  digit position, 0..N-1 with N = WIDTH/STEP.
- dir  output  1  direction of the last step (0 left, 1 right).
- step_pulse  output  1  high for one cycle when `pattern` has just stepped.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: pattern = INIT, pos = 0, dir = 0, step_pulse = 0, prescaler = 0.
- Prescaler:
  - Counts 0..DIV-1 while run=1 and mode != 11.
  - tick = (count == DIV-1). The counter wraps to 0 on tick.
  - Cleared to 0 when run=0, mode=11 or load=1.
  - DIV=1 gives a tick every cycle.
- Step event: step = (tick | step_now) & (mode != 11). A tick and a step_now in the same cycle produce exactly one step.
- Priority per edge: reset > load > step > hold.
- Load: pattern <= load_val, pos <= 0, dir <= 0, step_pulse <= 0. A step in the same cycle is discarded.
- Left step: pattern <= {pattern[WIDTH-STEP-1:0], pattern[WIDTH-1:WIDTH-STEP]}, pos <= (pos+1) mod N, dir <= 0.
- Right step: pattern <= {pattern[STEP-1:0], pattern[WIDTH-1:STEP]}, pos <= (pos-1) mod N, dir <= 1.
- Mode 00 always steps left. Mode 01 always steps right.
- Mode 10 (bounce) continues in the current dir, except:
  - dir=0 and pos=N-1: step right instead, dir <= 1.
  - dir=1 and pos=0: step left instead, dir <= 0.
  - Reversal takes effect on the same edge; there is no dwell cycle.
- Mode 11 (freeze): no steps occur; pattern, pos and dir hold; step_now is ignored.
- step_pulse is 1 in exactly the cycles where pattern shows a just-stepped value. Latency: step sampled at edge k, new pattern and step_pulse visible after edge k, step_pulse low after edge k+1 unless another step occurs.
- Mode changes take effect on the next step. pos and dir are not reset by a mode change.
- Reset asserted mid-run restores the reset values on that edge. The prescaler restarts from 0.

Test Plan (WIDTH=16, STEP=4, DIV=4, INIT=16'h0001):
1. Reset held 2 cycles:
   - pattern=0x0001, pos=0, dir=0, step_pulse=0.
   - With run=0 and no step_now, the pattern stays 0x0001 for 20 cycles.
2. Load 0x1234, mode=00, run=1:
   - Every 4 cycles: 0x2341 (pos1), 0x3412 (pos2), 0x4123 (pos3), 0x1234 (pos0, wrap).
   - step_pulse is 1 for exactly one cycle per step.
3. Load 0x1234, mode=01, run=1:
   - First tick gives 0x4123, pos=3, dir=1.
   - Next tick gives 0x3412, pos=2.
4. Load 0x000F, mode=10, run=1; pattern after successive ticks:
   - 0x00F0 (pos1), 0x0F00 (pos2), 0xF000 (pos3, dir0).
   - Then 0x0F00 (pos2, dir1), 0x00F0 (pos1), 0x000F (pos0).
   - Then 0x00F0 (pos1, dir0).
5. Manual and simultaneous events:
   - run=0, mode=00, step_now pulse: one step; 0x0001 -> 0x0010.
   - step_now coincident with a tick (run=1) gives one step, not two.
   - mode=11 with step_now: no change, step_pulse=0.
6. Priority and reset:
   - load=1 in the same cycle as a tick: pattern=load_val, no step_pulse, and the next step occurs 4 cycles later.
   - CPU_RESET asserted mid-bounce (pos2, dir1): the next cycle shows pattern=0x0001, pos=0, dir=0.
